uart_rx: RTL

// Serial UART receiver; the downstream partner of the team's UART transmitter.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Host-side bundle for the UART receiver: serial line in, byte plus status out.
interface uart_rx_if;
  logic       rx;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_avail;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  // Line driver and host consumer side.
  modport master (
    output rx, rd_ack,
    input  rx_data, rx_valid, rx_avail, parity_err, frame_err, overrun_err, busy
  );

  // Receiver side.
  modport slave (
    input  rx, rd_ack,
    output rx_data, rx_valid, rx_avail, parity_err, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, odd parity, 1 stop bit, one-deep holding register.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic             sync1_q, rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             perr_q, perr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_avail_q, rx_avail_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             commit;

  // Frame FSM, bit timing and holding-register update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bitn_d       = bitn_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_avail_d   = rx_avail_q;
    overrun_d    = overrun_q;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bitn_d  = 3'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = ~(^shreg_q ^ rx_s_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          commit       = 1'b1;
          rx_data_d    = shreg_q;
          parity_err_d = perr_q;
          frame_err_d  = ~rx_s_q;
          state_d      = rx_s_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // A commit outranks a coincident acknowledge; only an unacknowledged hold overruns.
    if (commit) begin
      rx_avail_d = 1'b1;
      if (rx_avail_q && !bus.rd_ack)     overrun_d = 1'b1;
      else if (rx_avail_q && bus.rd_ack) overrun_d = 1'b0;
    end else if (bus.rd_ack && rx_avail_q) begin
      rx_avail_d = 1'b0;
      overrun_d  = 1'b0;
    end

    rx_valid_d = commit;
    busy_d     = (state_d != S_IDLE);
  end

  // Synchronizer, state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitn_q       <= 3'd0;
      shreg_q      <= 8'd0;
      perr_q       <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_avail_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= bus.rx;
      rx_s_q       <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitn_q       <= bitn_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_avail_q   <= rx_avail_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_avail    = rx_avail_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_err = overrun_q;
  assign bus.busy        = busy_q;

endmodule
